// File: rtl/bcd_sevenseg_counter.sv
// Prescaled BCD up/down counter (0-9) with synchronous load and a registered
// active-low seven-segment decoder (segments a..g, 0 = lit).
module bcd_sevenseg_counter #(
  parameter int unsigned DIV = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       tick,
  output logic       carry,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  // DIV=1 still needs a 1-bit prescaler; it simply never leaves 0.
  localparam int unsigned PW = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_presc;
  logic [3:0]    r_digit;
  logic          r_tick;
  logic          r_carry;
  logic [6:0]    r_seg;

  logic          w_step;
  logic          w_wrap;
  logic [3:0]    w_next;
  logic [3:0]    w_load_digit;
  logic [6:0]    w_seg;

  assign w_step       = en && (r_presc == LAST);
  assign w_load_digit = (load_val > 4'd9) ? 4'd0 : load_val;

  always_comb begin
    w_next = r_digit;
    w_wrap = 1'b0;
    if (up) begin
      w_wrap = (r_digit == 4'd9);
      w_next = w_wrap ? 4'd0 : r_digit + 4'd1;
    end else begin
      w_wrap = (r_digit == 4'd0);
      w_next = w_wrap ? 4'd9 : r_digit - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_digit <= 4'd0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (load) begin
      r_presc <= '0;
      r_digit <= w_load_digit;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_step) begin
      r_presc <= '0;
      r_digit <= w_next;
      r_tick  <= 1'b1;
      r_carry <= w_wrap;
    end else begin
      if (en) begin
        r_presc <= r_presc + PW'(1);
      end
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end
  end

  // Bit 6 is segment a, bit 0 is segment g.
  always_comb begin
    w_seg = 7'b1111111;
    case (r_digit)
      4'd0: w_seg = 7'b0000001;
      4'd1: w_seg = 7'b1001111;
      4'd2: w_seg = 7'b0010010;
      4'd3: w_seg = 7'b0000110;
      4'd4: w_seg = 7'b1001100;
      4'd5: w_seg = 7'b0100100;
      4'd6: w_seg = 7'b0100000;
      4'd7: w_seg = 7'b0001111;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0000100;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Segments follow the digit register one cycle later, regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= 7'b0000001;
    end else begin
      r_seg <= w_seg;
    end
  end

  assign digit = r_digit;
  assign tick  = r_tick;
  assign carry = r_carry;
  assign a     = r_seg[6];
  assign b     = r_seg[5];
  assign c     = r_seg[4];
  assign d     = r_seg[3];
  assign e     = r_seg[2];
  assign f     = r_seg[1];
  assign g     = r_seg[0];

endmodule

// File: tb/tb_bcd_sevenseg_counter.sv
// Drives three counters (DIV = 4, 1, 2) with shared inputs; a cycle model checks
// every output each cycle, and directed literal checks pin the model.
module tb_bcd_sevenseg_counter;

  localparam int NI = 3;
  localparam int DIVS [NI] = '{4, 1, 2};
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic clk = 1'b0;
  logic rst, en, up, load;
  logic [3:0] load_val;

  logic [NI-1:0][3:0] d_digit;
  logic [NI-1:0]      d_tick;
  logic [NI-1:0]      d_carry;
  logic [NI-1:0][6:0] d_seg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      bcd_sevenseg_counter #(.DIV(DIVS[gi])) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .digit    (d_digit[gi]),
        .tick     (d_tick[gi]),
        .carry    (d_carry[gi]),
        .a        (d_seg[gi][6]),
        .b        (d_seg[gi][5]),
        .c        (d_seg[gi][4]),
        .d        (d_seg[gi][3]),
        .e        (d_seg[gi][2]),
        .f        (d_seg[gi][1]),
        .g        (d_seg[gi][0])
      );
    end
  endgenerate

  // Model: m_phase counts enabled cycles since the last step/load/reset.
  int m_phase [NI];
  int m_digit [NI];
  int m_shown [NI];
  bit m_tick  [NI];
  bit m_carry [NI];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) m_valid <= 1'b1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_phase[i] <= 0;
        m_digit[i] <= 0;
        m_shown[i] <= 0;
        m_tick[i]  <= 1'b0;
        m_carry[i] <= 1'b0;
      end else begin
        m_shown[i] <= m_digit[i];
        if (load) begin
          m_phase[i] <= 0;
          m_digit[i] <= (int'(load_val) > 9) ? 0 : int'(load_val);
          m_tick[i]  <= 1'b0;
          m_carry[i] <= 1'b0;
        end else if (en && (m_phase[i] + 1 == DIVS[i])) begin
          m_phase[i] <= 0;
          m_tick[i]  <= 1'b1;
          if (up) begin
            m_digit[i] <= (m_digit[i] + 1) % 10;
            m_carry[i] <= (m_digit[i] == 9);
          end else begin
            m_digit[i] <= (m_digit[i] + 9) % 10;
            m_carry[i] <= (m_digit[i] == 0);
          end
        end else begin
          if (en) m_phase[i] <= m_phase[i] + 1;
          m_tick[i]  <= 1'b0;
          m_carry[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("model_digit[%0d]", i), 32'(d_digit[i]), 32'(m_digit[i]));
        chk($sformatf("model_tick[%0d]", i),  32'(d_tick[i]),  32'(m_tick[i]));
        chk($sformatf("model_carry[%0d]", i), 32'(d_carry[i]), 32'(m_carry[i]));
        chk($sformatf("model_seg[%0d]", i),   32'(d_seg[i]),   32'(SEG_TAB[m_shown[i]]));
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(nm, act, exp);
    $display("check %-14s got %0h expected %0h", nm, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    run(1);
    for (int i = 0; i < NI; i++) begin
      lit($sformatf("rst_digit%0d", i), 32'(d_digit[i]), 32'd0);
      lit($sformatf("rst_tick%0d", i),  32'(d_tick[i]),  32'd0);
      lit($sformatf("rst_seg%0d", i),   32'(d_seg[i]),   32'b0000001);
    end

    // Counting up, DIV=4 and DIV=1
    rst = 1'b0; en = 1'b1;
    run(3);
    lit("t1_d_e3",   32'(d_digit[0]), 32'd0);
    lit("t1_tk_e3",  32'(d_tick[0]),  32'd0);
    run(1);
    lit("t1_d_e4",   32'(d_digit[0]), 32'd1);
    lit("t1_tk_e4",  32'(d_tick[0]),  32'd1);
    run(1);
    lit("t1_seg_e5", 32'(d_seg[0]),   32'b1001111);
    lit("t1_tk_e5",  32'(d_tick[0]),  32'd0);
    run(3);
    lit("t1_d_e8",   32'(d_digit[0]), 32'd2);
    lit("t1_d1_e8",  32'(d_digit[1]), 32'd8);

    // Up wrap on DIV=1
    run(1);
    lit("t2_d9",     32'(d_digit[1]), 32'd9);
    lit("t2_c9",     32'(d_carry[1]), 32'd0);
    run(1);
    lit("t2_d0",     32'(d_digit[1]), 32'd0);
    lit("t2_c0",     32'(d_carry[1]), 32'd1);
    lit("t2_seg9",   32'(d_seg[1]),   32'b0000100);
    run(1);
    lit("t2_d1",     32'(d_digit[1]), 32'd1);
    lit("t2_c1",     32'(d_carry[1]), 32'd0);
    lit("t2_seg0",   32'(d_seg[1]),   32'b0000001);

    // Down wrap on DIV=2 (and DIV=1)
    rst = 1'b1; run(1);
    rst = 1'b0; up = 1'b0;
    run(1);
    lit("t3_d_e1",   32'(d_digit[2]), 32'd0);
    lit("t3_d1_e1",  32'(d_digit[1]), 32'd9);
    lit("t3_c1_e1",  32'(d_carry[1]), 32'd1);
    run(1);
    lit("t3_d_e2",   32'(d_digit[2]), 32'd9);
    lit("t3_c_e2",   32'(d_carry[2]), 32'd1);
    run(1);
    lit("t3_c_e3",   32'(d_carry[2]), 32'd0);
    run(1);
    lit("t3_d_e4",   32'(d_digit[2]), 32'd8);
    lit("t3_c_e4",   32'(d_carry[2]), 32'd0);
    lit("t3_tk_e4",  32'(d_tick[2]),  32'd1);

    // Load coincident with a step condition
    rst = 1'b1; run(1);
    rst = 1'b0; up = 1'b1;
    run(3);
    load = 1'b1; load_val = 4'd7;
    run(1);
    load = 1'b0;
    lit("t4_d_ld",   32'(d_digit[0]), 32'd7);
    lit("t4_tk_ld",  32'(d_tick[0]),  32'd0);
    lit("t4_c_ld",   32'(d_carry[0]), 32'd0);
    lit("t4_d1_ld",  32'(d_digit[1]), 32'd7);
    lit("t4_tk1_ld", 32'(d_tick[1]),  32'd0);
    run(3);
    lit("t4_tk_e3",  32'(d_tick[0]),  32'd0);
    run(1);
    lit("t4_d_e4",   32'(d_digit[0]), 32'd8);
    lit("t4_tk_e4",  32'(d_tick[0]),  32'd1);
    load = 1'b1; load_val = 4'd12;
    run(1);
    load = 1'b0;
    lit("t4_ld12",   32'(d_digit[0]), 32'd0);
    lit("t4_ld12_1", 32'(d_digit[1]), 32'd0);

    // Hold: en low freezes the prescaler mid-period
    rst = 1'b1; run(1);
    rst = 1'b0;
    run(2);
    en = 1'b0;
    run(10);
    lit("t5_d_hold",  32'(d_digit[0]), 32'd0);
    lit("t5_tk_hold", 32'(d_tick[0]),  32'd0);
    lit("t5_d1_hold", 32'(d_digit[1]), 32'd2);
    en = 1'b1;
    run(1);
    lit("t5_tk_r1",   32'(d_tick[0]),  32'd0);
    run(1);
    lit("t5_tk_r2",   32'(d_tick[0]),  32'd1);
    lit("t5_d_r2",    32'(d_digit[0]), 32'd1);

    // Reset mid-period at digit 5
    rst = 1'b1; run(1);
    rst = 1'b0;
    run(22);
    lit("t6_d5",      32'(d_digit[0]), 32'd5);
    rst = 1'b1; run(1);
    rst = 1'b0;
    lit("t6_rst_d",   32'(d_digit[0]), 32'd0);
    lit("t6_rst_tk",  32'(d_tick[0]),  32'd0);
    lit("t6_rst_c",   32'(d_carry[0]), 32'd0);
    lit("t6_rst_seg", 32'(d_seg[0]),   32'b0000001);
    run(3);
    lit("t6_tk_e3",   32'(d_tick[0]),  32'd0);
    run(1);
    lit("t6_tk_e4",   32'(d_tick[0]),  32'd1);
    lit("t6_d_e4",    32'(d_digit[0]), 32'd1);

    // Mixed directed pattern, checked by the model only
    for (int k = 0; k < 80; k++) begin
      en       = (k % 7) != 3;
      up       = ((k / 10) % 2) == 0;
      load     = (k % 13) == 5;
      load_val = 4'(k % 16);
      run(1);
    end
    load = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
